// File: rtl/fixed_point_accumulator.sv
// Saturating frame accumulator for unsigned Q4.4 products.
// Sums N_TERMS accepted beats into an ACC_W-bit register, clamping at all-ones,
// and presents one registered sum per frame on a valid/ready output.
module fixed_point_accumulator #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned FRAC_W  = 4,
   parameter int unsigned ACC_W   = 10,
   parameter int unsigned N_TERMS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_sat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int unsigned CntW = $clog2(N_TERMS);

   typedef enum logic {StAcc, StHold} state_t;

   // Reject parameter sets the datapath cannot represent.
   if (ACC_W < DATA_W || FRAC_W > DATA_W || N_TERMS < 2 || N_TERMS > 255) begin : g_bad_params
      $error("fixed_point_accumulator: illegal parameter combination");
   end

   state_t            state_q;
   logic [ACC_W-1:0]  acc_q;
   logic [CntW-1:0]   cnt_q;
   logic              sat_q;

   logic [ACC_W:0]    sum;
   logic              ovf;
   logic [ACC_W-1:0]  sum_sat;
   logic              last_beat;

   // One-bit-wider add so the carry out flags overflow; clamp to all-ones.
   always_comb begin
      sum       = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
      ovf       = sum[ACC_W];
      sum_sat   = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      last_beat = (cnt_q == CntW'(N_TERMS - 1));
   end

   // Handshake flags derive only from registered state.
   always_comb begin
      in_ready = (state_q == StAcc);
      busy     = (cnt_q != '0);
   end

   // Frame FSM: accumulate in StAcc, present the result in StHold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StAcc;
         acc_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_valid <= 1'b0;
      end else if (clear) begin
         // Abort wins over any beat or output handshake this cycle.
         state_q   <= StAcc;
         acc_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state_q)
            StAcc: begin
               if (in_valid) begin
                  if (last_beat) begin
                     out_data  <= sum_sat;
                     out_sat   <= sat_q | ovf;
                     out_valid <= 1'b1;
                     acc_q     <= '0;
                     cnt_q     <= '0;
                     sat_q     <= 1'b0;
                     state_q   <= StHold;
                  end else begin
                     acc_q <= sum_sat;
                     sat_q <= sat_q | ovf;
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
            end
            StHold: begin
               // Intake reopens only on the cycle after the output is taken.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StAcc;
               end
            end
            default: state_q <= StAcc;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator: directed frames with literal expectations,
// then randomized traffic, all compared every cycle against a frame-level model.
module tb_fixed_point_accumulator;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ACC_W   = 10;
   localparam int unsigned N_TERMS = 8;
   localparam int unsigned MAX_SUM = (1 << ACC_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              clear = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ACC_W-1:0]  out_data;
   logic              out_sat;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              busy;

   int vectors = 0;
   int miscompares = 0;
   bit checking = 1'b0;

   fixed_point_accumulator #(
      .DATA_W  (DATA_W),
      .FRAC_W  (4),
      .ACC_W   (ACC_W),
      .N_TERMS (N_TERMS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Frame-level model: collect accepted beats, emit min(total, max) per frame.
   int unsigned beats[$];
   int unsigned m_data;
   bit          m_sat;
   bit          m_valid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats.delete();
         m_data  = 0;
         m_sat   = 1'b0;
         m_valid = 1'b0;
      end else if (clear) begin
         beats.delete();
         m_valid = 1'b0;
      end else if (m_valid) begin
         if (out_ready) m_valid = 1'b0;
      end else if (in_valid) begin
         beats.push_back(int'(in_data));
         if (beats.size() == N_TERMS) begin
            int unsigned total;
            total = 0;
            foreach (beats[i]) total += beats[i];
            m_data  = (total > MAX_SUM) ? MAX_SUM : total;
            m_sat   = (total > MAX_SUM);
            m_valid = 1'b1;
            beats.delete();
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
         chk("cyc_out_data", 32'(out_data), m_data);
         chk("cyc_out_sat", 32'(out_sat), 32'(m_sat));
         chk("cyc_in_ready", 32'(in_ready), 32'(!m_valid));
         chk("cyc_busy", 32'(busy), 32'(beats.size() != 0));
      end
   end

   // Present one beat and hold it until an edge where in_ready was high.
   task automatic beat(input logic [DATA_W-1:0] d);
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) chk("beat_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic frame_const(input logic [DATA_W-1:0] d);
      for (int i = 0; i < N_TERMS; i++) beat(d);
   endtask

   task automatic take(input string name, input logic [31:0] exp_data, input bit exp_sat);
      int guard;
      guard = 0;
      while (!out_valid && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_data"}, 32'(out_data), exp_data);
      chk({name, "_sat"}, 32'(out_sat), 32'(exp_sat));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_taken"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #12 rst_n = 1'b1;
      checking = 1'b1;
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);

      // 1: mixed frame, output one cycle after the last beat
      beat(8'h7E);
      beat(8'h24);
      for (int i = 0; i < 6; i++) beat(8'h10);
      chk("t1_latency", 32'(out_valid), 32'd1);
      take("t1", 32'h102, 1'b0);

      // 2: saturation, then a clean frame with the flag cleared
      frame_const(8'hFF);
      take("t2_sat", 32'h3FF, 1'b1);
      frame_const(8'h01);
      take("t2_small", 32'h008, 1'b0);

      // 3: output backpressure with inputs offered
      frame_const(8'h10);
      in_valid = 1'b1;
      in_data  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t3_hold_data", 32'(out_data), 32'h080);
         chk("t3_hold_ready", 32'(in_ready), 32'd0);
         chk("t3_hold_busy", 32'(busy), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("t3_release_valid", 32'(out_valid), 32'd0);
      chk("t3_release_ready", 32'(in_ready), 32'd1);

      // 4: gaps between beats
      for (int i = 0; i < N_TERMS; i++) begin
         repeat ($urandom_range(3)) begin
            @(posedge clk); #1;
         end
         beat(8'h18);
      end
      take("t4", 32'h0C0, 1'b0);

      // 5: clear mid-frame (with a beat offered that must be dropped), then in HOLD
      for (int i = 0; i < 3; i++) beat(8'h20);
      in_valid = 1'b1;
      in_data  = 8'h20;
      clear    = 1'b1;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("t5_clear_busy", 32'(busy), 32'd0);
      frame_const(8'h10);
      take("t5", 32'h080, 1'b0);
      frame_const(8'h10);
      clear     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      clear     = 1'b0;
      out_ready = 1'b0;
      chk("t5_hold_clear_valid", 32'(out_valid), 32'd0);
      chk("t5_hold_clear_ready", 32'(in_ready), 32'd1);

      // 6: asynchronous reset between edges
      for (int i = 0; i < 3; i++) beat(8'h33);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_data", 32'(out_data), 32'd0);
      chk("t6_rst_sat", 32'(out_sat), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      frame_const(8'h10);
      take("t6", 32'h080, 1'b0);

      // Random traffic: data, gaps, backpressure and occasional aborts
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_data   = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) :
                                               8'($urandom_range(200, 255));
         out_ready = ($urandom_range(2) != 0);
         clear     = ($urandom_range(63) == 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clear     = 1'b0;
      @(posedge clk); #1;

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
